// File: rtl/aer_pkg.sv
// ---------------------------------------------------------------------------
// aer_pkg
// Shared types and constants for the AER token encoder.
//   state_t  : frame position (IDLE, FS, SEL, SEP, DAT, FE)
//   phase_t  : handshake phase within a token state (RAISE, RTZ)
//   TOK_*    : bit positions of the five tokens/acks in a packed vector
//   helpers  : tok_onehot (index -> one-hot), bit_tok (data bit -> token),
//              cnt_width (bit-counter width for a field length)
// ---------------------------------------------------------------------------
package aer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FS   = 3'd1,
        SEL  = 3'd2,
        SEP  = 3'd3,
        DAT  = 3'd4,
        FE   = 3'd5
    } state_t;

    typedef enum logic {
        RAISE = 1'b0,
        RTZ   = 1'b1
    } phase_t;

    localparam int NUM_TOK = 5;

    localparam logic [2:0] TOK_FS   = 3'd0;
    localparam logic [2:0] TOK_X0   = 3'd1;
    localparam logic [2:0] TOK_ZERO = 3'd2;
    localparam logic [2:0] TOK_ONE  = 3'd3;
    localparam logic [2:0] TOK_FE   = 3'd4;

    function automatic logic [NUM_TOK-1:0] tok_onehot(input logic [2:0] idx);
        return {{(NUM_TOK-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [2:0] bit_tok(input logic b);
        return b ? TOK_ONE : TOK_ZERO;
    endfunction

    // A 1-bit field still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/aer_ack_sync.sv
// ---------------------------------------------------------------------------
// aer_ack_sync
// Two-flop synchroniser for the five decoder ack lines. Used only when the
// build defines AER_ACK_SYNC_EN (decoder on a different clock domain).
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   ack_i  : raw ack vector, indexed by TOK_*
//   ack_o  : synchronised ack vector, two cycles behind ack_i
// ---------------------------------------------------------------------------
module aer_ack_sync
    import aer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_TOK-1:0] ack_i,
    output logic [NUM_TOK-1:0] ack_o
);

    logic [NUM_TOK-1:0] meta_q;
    logic [NUM_TOK-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= ack_i;
            sync_q <= meta_q;
        end
    end

    assign ack_o = sync_q;

endmodule

// File: rtl/aer_token_encoder.sv
// ---------------------------------------------------------------------------
// aer_token_encoder
// Transmit side of the AER link. Accepts one event (select + data field) and
// sends it as a one-hot token frame:
//   Fs, SEL_W select bits (MSB first), X0, DAT_W data bits (MSB first), Fe
// Each bit is sent as Zero or One. Every token uses a 4-phase return-to-zero
// handshake against its own *_ack line.
// Parameters:
//   SEL_W, DAT_W : select / data field widths
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   ev_valid / ev_ready   : event request / encoder can accept this cycle
//   ev_sel, ev_data       : event fields, captured on accept
//   Fs, X0, Zero, One, Fe : registered token outputs (at most one high)
//   *_ack                 : decoder acks, one per token
//   busy                  : frame in progress
//   proto_err             : sticky flag, an ack other than the active
//                           token's ack was seen while busy
// Build option:
//   AER_ACK_SYNC_EN : route all acks through a 2-flop synchroniser first.
// ---------------------------------------------------------------------------
module aer_token_encoder
    import aer_pkg::*;
#(
    parameter int SEL_W = 1,
    parameter int DAT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic [SEL_W-1:0] ev_sel,
    input  logic [DAT_W-1:0] ev_data,
    output logic             Fs,
    output logic             X0,
    output logic             Zero,
    output logic             One,
    output logic             Fe,
    input  logic             Fs_ack,
    input  logic             X0_ack,
    input  logic             Zero_ack,
    input  logic             One_ack,
    input  logic             Fe_ack,
    output logic             busy,
    output logic             proto_err
);

    localparam int CNT_W = cnt_width((SEL_W > DAT_W) ? SEL_W : DAT_W);

    logic [NUM_TOK-1:0] ack_raw;
    logic [NUM_TOK-1:0] ack_use;

    assign ack_raw[TOK_FS]   = Fs_ack;
    assign ack_raw[TOK_X0]   = X0_ack;
    assign ack_raw[TOK_ZERO] = Zero_ack;
    assign ack_raw[TOK_ONE]  = One_ack;
    assign ack_raw[TOK_FE]   = Fe_ack;

`ifdef AER_ACK_SYNC_EN
    aer_ack_sync u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .ack_i (ack_raw),
        .ack_o (ack_use)
    );
`else
    assign ack_use = ack_raw;
`endif

    state_t             state_q;
    phase_t             phase_q;
    logic [2:0]         cur_tok_q;   // index of the token being handshaken
    logic [NUM_TOK-1:0] tok_q;
    logic               busy_q;
    logic               proto_err_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SEL_W-1:0]   sel_q;
    logic [DAT_W-1:0]   dat_q;

    logic               exp_ack;
    logic               stray_ack;
    logic [CNT_W-1:0]   cnt_dec;
    logic [SEL_W-1:0]   sel_shift;
    logic [DAT_W-1:0]   dat_shift;

    state_t             state_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [2:0]         tok_idx_d;

    assign exp_ack   = |(ack_use &  tok_onehot(cur_tok_q));
    assign stray_ack = |(ack_use & ~tok_onehot(cur_tok_q));
    assign cnt_dec   = cnt_q - 1'b1;
    assign sel_shift = sel_q >> cnt_dec;
    assign dat_shift = dat_q >> cnt_dec;

    // Held low during reset; otherwise a new frame may only start once the
    // decoder has released every ack line.
    assign ev_ready = !reset && (state_q == IDLE) && (ack_use == '0);

    // Successor token, used when the current token's RTZ phase completes.
    always_comb begin
        state_d   = IDLE;
        cnt_d     = cnt_q;
        tok_idx_d = TOK_FE;
        case (state_q)
            FS: begin
                state_d   = SEL;
                cnt_d     = CNT_W'(SEL_W - 1);
                tok_idx_d = bit_tok(sel_q[SEL_W-1]);
            end
            SEL: begin
                if (cnt_q == '0) begin
                    state_d   = SEP;
                    tok_idx_d = TOK_X0;
                end else begin
                    state_d   = SEL;
                    cnt_d     = cnt_dec;
                    tok_idx_d = bit_tok(sel_shift[0]);
                end
            end
            SEP: begin
                state_d   = DAT;
                cnt_d     = CNT_W'(DAT_W - 1);
                tok_idx_d = bit_tok(dat_q[DAT_W-1]);
            end
            DAT: begin
                if (cnt_q == '0) begin
                    state_d   = FE;
                    tok_idx_d = TOK_FE;
                end else begin
                    state_d   = DAT;
                    cnt_d     = cnt_dec;
                    tok_idx_d = bit_tok(dat_shift[0]);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= RAISE;
            cur_tok_q   <= TOK_FS;
            tok_q       <= '0;
            busy_q      <= 1'b0;
            proto_err_q <= 1'b0;
            cnt_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
        end else begin
            if (busy_q && stray_ack) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (ev_valid && ev_ready) begin
                        sel_q     <= ev_sel;
                        dat_q     <= ev_data;
                        state_q   <= FS;
                        phase_q   <= RAISE;
                        cur_tok_q <= TOK_FS;
                        tok_q     <= tok_onehot(TOK_FS);
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    if (phase_q == RAISE) begin
                        if (exp_ack) begin
                            tok_q   <= '0;
                            phase_q <= RTZ;
                        end
                    end else if (!exp_ack) begin
                        state_q   <= state_d;
                        cnt_q     <= cnt_d;
                        cur_tok_q <= tok_idx_d;
                        phase_q   <= RAISE;
                        if (state_d == IDLE) begin
                            tok_q  <= '0;
                            busy_q <= 1'b0;
                        end else begin
                            tok_q  <= tok_onehot(tok_idx_d);
                        end
                    end
                end
            endcase
        end
    end

    assign Fs        = tok_q[TOK_FS];
    assign X0        = tok_q[TOK_X0];
    assign Zero      = tok_q[TOK_ZERO];
    assign One       = tok_q[TOK_ONE];
    assign Fe        = tok_q[TOK_FE];
    assign busy      = busy_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_aer_token_encoder.sv
`timescale 1ns/1ps
// Testbench for aer_token_encoder. Two instances: a 1/1-bit encoder (u_dut)
// and a 2/3-bit encoder (u_wide). Each is answered by a decoder model that
// mirrors tokens onto acks one cycle late. Expected token sequences are
// queued when events are driven and popped as token rising edges appear.
module tb_aer_token_encoder;

    localparam int T_FS = 0, T_X0 = 1, T_ZERO = 2, T_ONE = 3, T_FE = 4;
    localparam int BUDGET = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // narrow instance
    logic       m_valid = 1'b0;
    logic       m_ready, m_busy, m_perr;
    logic [0:0] m_sel = '0, m_data = '0;
    logic [4:0] m_tok, m_ack;
    logic [4:0] m_mirror = '0;
    logic [4:0] m_inj = '0;
    logic       m_hold_one = 1'b0;

    // wide instance
    logic       w_valid = 1'b0;
    logic       w_ready, w_busy, w_perr;
    logic [1:0] w_sel = '0;
    logic [2:0] w_data = '0;
    logic [4:0] w_tok, w_ack;
    logic [4:0] w_mirror = '0;

    int         m_exp[$];
    int         w_exp[$];
    logic [4:0] m_prev = '0, w_prev = '0;
    int         m_len[5];
    bit         chk_len = 1'b0;

    aer_token_encoder #(.SEL_W(1), .DAT_W(1)) u_dut (
        .clk(clk), .reset(reset),
        .ev_valid(m_valid), .ev_ready(m_ready), .ev_sel(m_sel), .ev_data(m_data),
        .Fs(m_tok[0]), .X0(m_tok[1]), .Zero(m_tok[2]), .One(m_tok[3]), .Fe(m_tok[4]),
        .Fs_ack(m_ack[0]), .X0_ack(m_ack[1]), .Zero_ack(m_ack[2]),
        .One_ack(m_ack[3]), .Fe_ack(m_ack[4]),
        .busy(m_busy), .proto_err(m_perr)
    );

    aer_token_encoder #(.SEL_W(2), .DAT_W(3)) u_wide (
        .clk(clk), .reset(reset),
        .ev_valid(w_valid), .ev_ready(w_ready), .ev_sel(w_sel), .ev_data(w_data),
        .Fs(w_tok[0]), .X0(w_tok[1]), .Zero(w_tok[2]), .One(w_tok[3]), .Fe(w_tok[4]),
        .Fs_ack(w_ack[0]), .X0_ack(w_ack[1]), .Zero_ack(w_ack[2]),
        .One_ack(w_ack[3]), .Fe_ack(w_ack[4]),
        .busy(w_busy), .proto_err(w_perr)
    );

    // Decoder model: ack follows token one cycle later.
    always @(posedge clk) begin
        m_mirror <= m_tok;
        w_mirror <= w_tok;
    end
    assign m_ack = m_mirror | m_inj | {1'b0, m_hold_one, 3'b000};
    assign w_ack = w_mirror;

    // Advance to the next negedge and run the scoreboard on both instances.
    task automatic cycle();
        logic [4:0] cur, prv;
        int e;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            cur = (k == 0) ? m_tok : w_tok;
            prv = (k == 0) ? m_prev : w_prev;
            checks++;
            if ($countones(cur) > 1) begin
                errors++;
                $display("FAIL onehot dut%0d cycle %0d: tokens=%b, required at most one high", k, cyc, cur);
            end
            for (int i = 0; i < 5; i++) begin
                if (cur[i] && !prv[i]) begin
                    checks++;
                    if (k == 0 && m_exp.size() > 0)      e = m_exp.pop_front();
                    else if (k == 1 && w_exp.size() > 0) e = w_exp.pop_front();
                    else                                 e = -1;
                    if (e != i) begin
                        errors++;
                        $display("FAIL token_order dut%0d cycle %0d: got token %0d, expected %0d", k, cyc, i, e);
                    end else begin
                        $display("dut%0d cycle %0d: token %0d", k, cyc, i);
                    end
                    if (k == 0) m_len[i] = 1;
                end else if (k == 0 && cur[i]) begin
                    m_len[i]++;
                end else if (k == 0 && chk_len && prv[i] && !cur[i]) begin
                    checks++;
                    if (m_len[i] != 2) begin
                        errors++;
                        $display("FAIL token_width cycle %0d: token %0d high %0d cycles, expected 2", cyc, i, m_len[i]);
                    end
                end
            end
            if (k == 0) m_prev = cur;
            else        w_prev = cur;
        end
    endtask

    task automatic send_event(input int k, output bit timeout);
        int n = 0;
        if (k == 0) m_valid = 1'b1; else w_valid = 1'b1;
        while (!((k == 0) ? m_ready : w_ready) && n < BUDGET) begin
            cycle();
            n++;
        end
        cycle();
        if (k == 0) m_valid = 1'b0; else w_valid = 1'b0;
        timeout = (n >= BUDGET);
    endtask

    task automatic wait_idle(input int k, output bit timeout);
        int n = 0;
        while (((k == 0) ? m_busy : w_busy) && n < BUDGET) begin
            cycle();
            n++;
        end
        timeout = (n >= BUDGET);
    endtask

    task automatic wait_tok(input int idx, input logic level, output bit timeout);
        int n = 0;
        while (m_tok[idx] !== level && n < BUDGET) begin
            cycle();
            n++;
        end
        timeout = (n >= BUDGET);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle();
        checks++; if (m_tok !== 5'b0)  begin errors++; $display("FAIL reset_tokens: got %b, expected 00000", m_tok); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", m_busy); end
        checks++; if (m_perr !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b, expected 0", m_perr); end
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_reset: got %b, expected 0", m_ready); end
        reset = 1'b0;
        cycle();
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b, expected 1", m_ready); end
        checks++; if (w_ready !== 1'b1) begin errors++; $display("FAIL reset_wide_ready: got %b, expected 1", w_ready); end
    endtask

    task automatic test_basic_frame();
        bit to;
        chk_len = 1'b1;
        m_sel = 1'b1; m_data = 1'b1;
        m_exp.push_back(T_FS); m_exp.push_back(T_ONE); m_exp.push_back(T_X0);
        m_exp.push_back(T_ONE); m_exp.push_back(T_FE);
        send_event(0, to);
        checks++; if (to) begin errors++; $display("FAIL basic_accept: ev_ready never high"); end
        checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b, expected 1", m_busy); end
        // A second request with different fields while busy must be ignored.
        m_sel = 1'b0; m_data = 1'b0; m_valid = 1'b1;
        repeat (3) cycle();
        checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_busy: got %b, expected 0", m_ready); end
        m_valid = 1'b0;
        wait_idle(0, to);
        checks++; if (to) begin errors++; $display("FAIL basic_done: busy stuck high"); end
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_end: got %b, expected 1", m_ready); end
        checks++; if (m_exp.size() != 0) begin errors++; $display("FAIL basic_sb_empty: %0d tokens missing, expected 0", m_exp.size()); end
        checks++; if (m_perr !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b, expected 0", m_perr); end
        chk_len = 1'b0;
    endtask

    task automatic test_wide_fields();
        bit to;
        w_sel = 2'b10; w_data = 3'b011;
        w_exp.push_back(T_FS);   w_exp.push_back(T_ONE); w_exp.push_back(T_ZERO);
        w_exp.push_back(T_X0);   w_exp.push_back(T_ZERO); w_exp.push_back(T_ONE);
        w_exp.push_back(T_ONE);  w_exp.push_back(T_FE);
        send_event(1, to);
        checks++; if (to) begin errors++; $display("FAIL wide_accept: ev_ready never high"); end
        wait_idle(1, to);
        checks++; if (to) begin errors++; $display("FAIL wide_done: busy stuck high"); end
        checks++; if (w_exp.size() != 0) begin errors++; $display("FAIL wide_sb_empty: %0d tokens missing, expected 0", w_exp.size()); end
        checks++; if (w_perr !== 1'b0) begin errors++; $display("FAIL wide_perr: got %b, expected 0", w_perr); end
    endtask

    task automatic test_slow_ack();
        bit to;
        m_sel = 1'b1; m_data = 1'b0;
        m_exp.push_back(T_FS); m_exp.push_back(T_ONE); m_exp.push_back(T_X0);
        m_exp.push_back(T_ZERO); m_exp.push_back(T_FE);
        send_event(0, to);
        wait_tok(T_ONE, 1'b1, to);
        checks++; if (to) begin errors++; $display("FAIL slow_one_rise: One never rose"); end
        wait_tok(T_ONE, 1'b0, to);
        checks++; if (to) begin errors++; $display("FAIL slow_one_fall: One never fell"); end
        m_hold_one = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (m_tok !== 5'b0) begin
                errors++;
                $display("FAIL slow_hold cycle %0d: tokens=%b, expected 00000", cyc, m_tok);
            end
        end
        m_hold_one = 1'b0;
        wait_idle(0, to);
        checks++; if (to) begin errors++; $display("FAIL slow_done: busy stuck high"); end
        checks++; if (m_exp.size() != 0) begin errors++; $display("FAIL slow_sb_empty: %0d tokens missing, expected 0", m_exp.size()); end
        checks++; if (m_perr !== 1'b0) begin errors++; $display("FAIL slow_perr: got %b, expected 0", m_perr); end
    endtask

    task automatic test_spurious_ack();
        bit to;
        m_sel = 1'b1; m_data = 1'b1;
        m_exp.push_back(T_FS); m_exp.push_back(T_ONE); m_exp.push_back(T_X0);
        m_exp.push_back(T_ONE); m_exp.push_back(T_FE);
        send_event(0, to);
        wait_tok(T_ONE, 1'b1, to);
        checks++; if (to) begin errors++; $display("FAIL spur_one_rise: One never rose"); end
        checks++; if (m_perr !== 1'b0) begin errors++; $display("FAIL spur_perr_before: got %b, expected 0", m_perr); end
        m_inj = 5'b10000;
        cycle();
        m_inj = 5'b00000;
        checks++; if (m_perr !== 1'b1) begin errors++; $display("FAIL spur_perr_set: got %b, expected 1", m_perr); end
        wait_idle(0, to);
        checks++; if (to) begin errors++; $display("FAIL spur_done: busy stuck high"); end
        checks++; if (m_perr !== 1'b1) begin errors++; $display("FAIL spur_perr_sticky: got %b, expected 1", m_perr); end
        checks++; if (m_exp.size() != 0) begin errors++; $display("FAIL spur_sb_empty: %0d tokens missing, expected 0", m_exp.size()); end
    endtask

    task automatic test_midframe_reset();
        bit to;
        int n;
        m_sel = 1'b0; m_data = 1'b1;
        m_exp.push_back(T_FS); m_exp.push_back(T_ZERO); m_exp.push_back(T_X0);
        send_event(0, to);
        wait_tok(T_X0, 1'b1, to);
        checks++; if (to) begin errors++; $display("FAIL mrst_x0_rise: X0 never rose"); end
        reset = 1'b1;
        cycle();
        checks++; if (m_tok !== 5'b0)  begin errors++; $display("FAIL mrst_tokens: got %b, expected 00000", m_tok); end
        checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b, expected 0", m_busy); end
        checks++; if (m_perr !== 1'b0) begin errors++; $display("FAIL mrst_perr: got %b, expected 0", m_perr); end
        reset = 1'b0;
        n = 0;
        while (m_ready !== 1'b1 && n < BUDGET) begin
            cycle();
            n++;
        end
        checks++; if (n >= BUDGET) begin errors++; $display("FAIL mrst_ready: ev_ready never returned"); end
        checks++; if (m_exp.size() != 0) begin errors++; $display("FAIL mrst_sb_partial: %0d tokens missing, expected 0", m_exp.size()); end
        m_sel = 1'b1; m_data = 1'b0;
        m_exp.push_back(T_FS); m_exp.push_back(T_ONE); m_exp.push_back(T_X0);
        m_exp.push_back(T_ZERO); m_exp.push_back(T_FE);
        send_event(0, to);
        wait_idle(0, to);
        checks++; if (to) begin errors++; $display("FAIL mrst_fresh_done: busy stuck high"); end
        checks++; if (m_exp.size() != 0) begin errors++; $display("FAIL mrst_fresh_sb: %0d tokens missing, expected 0", m_exp.size()); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int n;
        m_sel = 1'b0; m_data = 1'b0;
        m_exp.push_back(T_FS); m_exp.push_back(T_ZERO); m_exp.push_back(T_X0);
        m_exp.push_back(T_ZERO); m_exp.push_back(T_FE);
        m_exp.push_back(T_FS); m_exp.push_back(T_ONE); m_exp.push_back(T_X0);
        m_exp.push_back(T_ONE); m_exp.push_back(T_FE);
        m_valid = 1'b1;
        n = 0;
        while (m_ready !== 1'b1 && n < BUDGET) begin
            cycle();
            n++;
        end
        cycle();
        // first event is now captured; present the second one
        m_sel = 1'b1; m_data = 1'b1;
        n = 0;
        while (m_busy && n < BUDGET) begin
            cycle();
            n++;
        end
        checks++; if (n >= BUDGET) begin errors++; $display("FAIL b2b_first_done: busy stuck high"); end
        checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_rise: got %b, expected 1", m_ready); end
        cycle();
        m_valid = 1'b0;
        checks++; if (m_busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy=%b, expected 1", m_busy); end
        wait_idle(0, to);
        checks++; if (to) begin errors++; $display("FAIL b2b_done: busy stuck high"); end
        checks++; if (m_exp.size() != 0) begin errors++; $display("FAIL b2b_sb_empty: %0d tokens missing, expected 0", m_exp.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_wide_fields();
        test_slow_ack();
        test_spurious_ack();
        test_midframe_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
